// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. A request is picked
// round-robin in IDLE, its operands are registered and presented to the ALU
// for one cycle (EXEC), and the captured result is returned to the granted
// requester through a held response handshake (RESP).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqX_valid/ready/op/a/b       request handshake and operation, X = 0,1
//   rspX_valid/ready              response handshake, X = 0,1
//   rsp_data                      result, valid while a rspX_valid is high
//   alu_ctrl, src_A, src_B        registered drive to the ALU
//   alu_result                    combinational result from the ALU
//   busy                          high whenever not in IDLE
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_data,
  output logic [3:0]   alu_ctrl,
  output logic [N-1:0] src_A,
  output logic [N-1:0] src_B,
  input  logic [N-1:0] alu_result,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   prio;
  logic   owner;
  logic   grant0, grant1, accept, rsp_taken;

  // Grant is only offered in IDLE; on a tie, prio names the winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !prio)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
  end

  assign accept    = grant0 | grant1;
  assign rsp_taken = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state;
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: if (accept) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (rsp_taken) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand registers drive the ALU directly, so the ALU inputs only move
  // on an accept and otherwise hold the last operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      alu_ctrl <= '0;
      src_A    <= '0;
      src_B    <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        owner    <= grant1;
        prio     <= !grant1;
        alu_ctrl <= grant1 ? req1_op : req0_op;
        src_A    <= grant1 ? req1_a  : req0_a;
        src_B    <= grant1 ? req1_b  : req0_b;
      end
      if (state == EXEC) rsp_data <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Directed sequences cover the reset state, single-op latency, arbitration,
// backpressure, opcode corner cases, reset mid-operation and starvation,
// followed by randomized traffic from both requesters.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [N-1:0] rsp_data;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] src_A, src_B, alu_result;
  logic         busy;

  typedef struct {
    bit           owner;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] data;
  } expect_t;

  expect_t sb[$];
  expect_t entry;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int acceptCycle = 0;
  int acceptCount0 = 0;
  int countBefore;
  bit lastServed = 1'b1;
  bit execPending = 1'b0;
  bit rspSeen = 1'b0;
  bit grantSide;
  bit seenRsp;
  bit done0, done1;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_ctrl(alu_ctrl), .src_A(src_A), .src_B(src_B),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: stands in for the shared ALU and also gives the
  // expected result of any request.
  function automatic logic [N-1:0] aluFunction(input logic [3:0] op,
                                               input logic [N-1:0] a,
                                               input logic [N-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a ^ b;
      4'd2:    return a - b;
      4'd3:    return a + b;
      4'd4:    return b;
      4'd5:    return ~a;
      default: return '0;
    endcase
  endfunction

  assign alu_result = aluFunction(alu_ctrl, src_A, src_B);

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out at cycle %0d", name, cycle);
  endtask

  // Raises a request and holds it until the handshake completes; returns
  // #1 after the accepting edge. keepValid leaves valid high for a re-issue.
  task automatic applyStimulus(input bit side, input logic [3:0] op,
                               input logic [N-1:0] a, input logic [N-1:0] b,
                               input bit keepValid);
    bit got;
    got = 1'b0;
    if (!side) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (side ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) reportTimeout(side ? "accept1" : "accept0");
    @(posedge clk);
    #1;
    if (!keepValid) begin
      if (!side) req0_valid = 1'b0;
      else       req1_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) reportTimeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks arbitration against a last-served model, pushes the
  // expected response on each accept, and pops/compares on each response.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      sb.delete();
      lastServed  = 1'b1;
      execPending = 1'b0;
    end else begin
      if (busy) checkOutput("ready_while_busy", 64'({req0_ready, req1_ready}), 64'd0);
      if (req0_ready || req1_ready) begin
        checkOutput("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
        grantSide = req1_ready;
        if (req0_valid && req1_valid)
          checkOutput("arb_grant", 64'(grantSide), 64'(!lastServed));
        else
          checkOutput("grant_valid", 64'(grantSide ? req1_valid : req0_valid), 64'd1);
        entry.owner = grantSide;
        entry.op    = grantSide ? req1_op : req0_op;
        entry.a     = grantSide ? req1_a  : req0_a;
        entry.b     = grantSide ? req1_b  : req0_b;
        entry.data  = aluFunction(entry.op, entry.a, entry.b);
        sb.push_back(entry);
        lastServed  = grantSide;
        acceptCycle = cycle;
        execPending = 1'b1;
        rspSeen     = 1'b0;
        if (!grantSide) acceptCount0++;
      end else if (!busy && (req0_valid || req1_valid)) begin
        checkOutput("idle_grant", 64'(req0_ready | req1_ready), 64'd1);
      end
      if (execPending && cycle == acceptCycle + 1 && sb.size() > 0) begin
        checkOutput("exec_ctrl", 64'(alu_ctrl), 64'(sb[sb.size()-1].op));
        checkOutput("exec_src_A", 64'(src_A), 64'(sb[sb.size()-1].a));
        checkOutput("exec_src_B", 64'(src_B), 64'(sb[sb.size()-1].b));
        execPending = 1'b0;
      end
      if (rsp0_valid || rsp1_valid) begin
        checkOutput("rsp_exclusive", 64'(rsp0_valid & rsp1_valid), 64'd0);
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp0_valid | rsp1_valid), 64'd0);
        end else begin
          checkOutput("rsp_owner", 64'(rsp1_valid), 64'(sb[0].owner));
          checkOutput("rsp_data", 64'(rsp_data), 64'(sb[0].data));
          if (!rspSeen) checkOutput("rsp_latency", 64'(cycle - acceptCycle), 64'd2);
          rspSeen = 1'b1;
          if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
            void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("reset_req1_ready", 64'(req1_ready), 64'd0);
    checkOutput("reset_rsp0_valid", 64'(rsp0_valid), 64'd0);
    checkOutput("reset_rsp1_valid", 64'(rsp1_valid), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
    checkOutput("reset_src_A", 64'(src_A), 64'd0);
    checkOutput("reset_src_B", 64'(src_B), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD with cycle-exact timing.
    req0_op = 4'd3; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("single_req0_ready", 64'(req0_ready), 64'd1);
    checkOutput("single_req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("single_alu_ctrl", 64'(alu_ctrl), 64'd3);
    checkOutput("single_src_A", 64'(src_A), 64'd5);
    checkOutput("single_src_B", 64'(src_B), 64'd7);
    checkOutput("single_rsp0_early", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    checkOutput("single_rsp0_valid", 64'(rsp0_valid), 64'd1);
    checkOutput("single_rsp_data", 64'(rsp_data), 64'd12);
    checkOutput("single_rsp1_valid", 64'(rsp1_valid), 64'd0);
    @(negedge clk);
    checkOutput("single_rsp0_done", 64'(rsp0_valid), 64'd0);
    checkOutput("hold_alu_ctrl", 64'(alu_ctrl), 64'd3);
    checkOutput("hold_src_A", 64'(src_A), 64'd5);
    waitIdle();

    // Two simultaneous pairs; grant alternates.
    repeat (2) begin
      fork
        applyStimulus(1'b0, 4'd2, 32'd10, 32'd3, 1'b0);
        applyStimulus(1'b1, 4'd1, 32'hF0, 32'hFF, 1'b0);
      join
      waitIdle();
    end

    // Backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    applyStimulus(1'b1, 4'd4, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    fork
      applyStimulus(1'b0, 4'd3, 32'd2, 32'd3, 1'b0);
      begin
        seenRsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (rsp1_valid) begin
            seenRsp = 1'b1;
            break;
          end
        end
        if (!seenRsp) reportTimeout("bp_rsp1");
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
          checkOutput("bp_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
          checkOutput("bp_req0_ready", 64'(req0_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
      end
    join
    waitIdle();

    // Undefined opcode and NOT.
    applyStimulus(1'b0, 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
    waitIdle();

    // Reset during EXEC drops the operation.
    applyStimulus(1'b0, 4'd3, 32'd1, 32'd1, 1'b0);
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    checkOutput("midrst_src_A", 64'(src_A), 64'd0);
    checkOutput("midrst_src_B", 64'(src_B), 64'd0);
    checkOutput("midrst_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("midrst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_rsp0", 64'(rsp0_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    fork
      applyStimulus(1'b0, 4'd3, 32'd2, 32'd2, 1'b0);
      applyStimulus(1'b1, 4'd0, 32'hFF00, 32'h0FF0, 1'b0);
    join
    waitIdle();

    // Requester 0 streams; requester 1 raised once must not wait past it.
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(1'b0, 4'd3, 32'(i), 32'd100, i < 3);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        countBefore = acceptCount0;
        applyStimulus(1'b1, 4'd1, 32'hAAAA, 32'h5555, 1'b0);
        checkOutput("starvation_req0_accepts", 64'(acceptCount0 - countBefore), 64'd0);
      end
    join
    waitIdle();

    // Random traffic from both sides with random response backpressure.
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          applyStimulus(1'b0, 4'($urandom_range(0, 15)), 32'($urandom()),
                        32'($urandom()), 1'b0);
        end
        done0 = 1'b1;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          applyStimulus(1'b1, 4'($urandom_range(0, 15)), 32'($urandom()),
                        32'($urandom()), 1'b0);
        end
        done1 = 1'b1;
      end
      begin
        while (!(done0 && done1)) begin
          @(posedge clk);
          #1;
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath between two requesters (e.g. the execute stage and an address/loop-control unit) with a valid/ready handshake per side. It selects one request at a time round-robin, registers that request's operands, drives them to the ALU for one cycle, and captures the result. The result is then returned to the granted requester through a held response handshake. The block sits between the requesters and the `alu` instance; the ALU's `alu_ctrl`, `src_A` and `src_B` are driven only by this block.

## Interface
- N, 32, operand/result width; must match the ALU's N
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  ALU opcode: 0 AND, 1 XOR, 2 SUB, 3 ADD, 4 MOVE(B), 5 NOT(A), others give result 0
- req0_a, req0_b  in  N  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, for requester 1
- rsp0_valid  out  1  result available for requester 0
- rsp1_valid  out  1  result available for requester 1
- rsp0_ready, rsp1_ready  in  1  requester takes the result
- rsp_data  out  N  result; valid while either rsp*_valid is high
- alu_ctrl  out  4  to ALU
- src_A, src_B  out  N  to ALU
- alu_result  in  N  from ALU (combinational)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqX_valid, grant one requester: if only one is valid, grant it; if both are valid, grant the one indicated by priority pointer `prio` (reset 0).
  - Assert the granted reqX_ready combinationally, the same cycle. The ready may depend on valid.
  - On the edge, latch op/a/b into the operand registers, record `owner`, set `prio` to the other requester, and go to EXEC.
- EXEC:
  - alu_ctrl/src_A/src_B are driven from the operand registers. They are always register-driven and never combinational from req inputs.
  - On the edge, capture alu_result into the rsp_data register and go to RESP.
- RESP:
  - Assert rspX_valid for `owner` only.
  - When rspX_ready is high, go to IDLE on the edge.
  - No new request is accepted in RESP.
- Requesters must hold valid/op/a/b stable until ready; the block does not check this.
- Opcodes 6–15 pass through unchanged and return 0. The block adds no error flag.
- SUB is src_A − src_B; the block performs no arithmetic itself.

## Timing
- Reset values:
  - State IDLE, prio 0, owner 0.
  - Operand registers 0, so alu_ctrl=0, src_A=0, src_B=0.
  - rsp_data 0, all valid/ready outputs 0, busy 0.
- Reset is asynchronous; asserting rst mid-operation (EXEC or RESP) returns to IDLE immediately. The in-flight result is dropped with no response.
- Latency: accept in cycle k (valid & ready); EXEC in k+1; rspX_valid high from k+2.
- rsp_data and rspX_valid hold stable until the cycle rspX_ready is high. With ready already high, RESP lasts one cycle.
- Throughput: at most one operation per 3 cycles (IDLE, EXEC, RESP). This holds with continuous requests and immediate rsp_ready.
- ALU outputs hold their last operands after RESP/IDLE; they change only on accept.
- A request raised while busy waits in IDLE order. Round-robin guarantees a waiting requester is served within one other operation.
- rspX_ready while rspX_valid is low is ignored.

## Test plan
- Single op: after reset, req0 ADD a=5 b=7 → req0_ready same cycle, alu_ctrl=3 src_A=5 src_B=7 next cycle, rsp0_valid with rsp_data=12 two cycles after accept; rsp1_valid stays 0.
- Arbitration: both valid from reset, req0 SUB 10−3, req1 XOR 0xF0^0xFF, rsp_ready tied high → req0 served first (rsp_data=7), then req1 (0x0F). A second simultaneous pair is served req0 then req1 again, since prio alternates.
- Backpressure: req1 MOVE b=0xDEADBEEF, rsp1_ready low 5 cycles → rsp1_valid and rsp_data=0xDEADBEEF held all 5 cycles; req0_valid high meanwhile gets no ready until after the RESP exit.
- Invalid opcode: req0_op=9, a=b=0xFFFFFFFF → rsp_data=0. NOT: op=5 a=0 → rsp_data=0xFFFFFFFF.
- Reset mid-op: accept req0 ADD 1+1, assert rst during EXEC → all outputs at reset values immediately, no rsp0_valid. The next request is then accepted normally, with prio=0.
- Starvation: req0_valid held high continuously with re-issued ops, req1 raised once → req1 is accepted at the first IDLE after req0's current operation.
